// File: rtl/pc_pkg.sv
// Shared types, defaults and helpers for the IF-stage program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_IDLE = 2'd0,
        PC_RUN  = 2'd1,
        PC_HOLD = 2'd2
    } pc_state_e;

    localparam int          PC_DEF_XLEN         = 32;
    localparam logic [31:0] PC_DEF_RESET_VECTOR = 32'h0000_0000;
    localparam int          PC_DEF_INSN_BYTES   = 4;

    // log2 of the instruction size (1, 2, 4 or 8 bytes)
    function automatic int align_bits(input int insn_bytes);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if ((32'sd1 <<< i) == insn_bytes) begin
                n = i;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Control and fetch-address bundle between the PC generator and its neighbours.
interface pc_gen_if
    import pc_pkg::*;
#(
    parameter int XLEN = PC_DEF_XLEN
) ();

    logic            start_i;
    logic            stall_i;
    logic            pc_write_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic [XLEN-1:0] pc_o;
    logic            pc_valid_o;
    logic            misalign_o;
    logic            redirect_pending_o;

    modport master (
        output start_i, stall_i, pc_write_i, redirect_i, redirect_pc_i,
        input  pc_o, pc_valid_o, misalign_o, redirect_pending_o
    );

    modport slave (
        input  start_i, stall_i, pc_write_i, redirect_i, redirect_pc_i,
        output pc_o, pc_valid_o, misalign_o, redirect_pending_o
    );

endinterface

// File: rtl/pc_redirect_buf.sv
// Pending redirect target with valid flag and misalignment pulse.
// capture together with clear means the target goes straight into the PC:
// only the misalignment check is recorded, nothing is kept pending.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int XLEN       = PC_DEF_XLEN,
    parameter int INSN_BYTES = PC_DEF_INSN_BYTES
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            capture,
    input  logic            clear,
    input  logic [XLEN-1:0] target_i,
    output logic [XLEN-1:0] target_o,
    output logic            valid_o,
    output logic            misalign_o
);

    localparam int              ALIGN_BITS = align_bits(INSN_BYTES);
    localparam logic [XLEN-1:0] LOW_MASK   = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [XLEN-1:0] target_r;
    logic            valid_r;
    logic            misalign_r;

    // Hold the newest stalled redirect and flag misaligned targets for one cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            target_r   <= '0;
            valid_r    <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= capture & (|(target_i & LOW_MASK));
            if (clear) begin
                target_r <= '0;
                valid_r  <= 1'b0;
            end else if (capture) begin
                target_r <= target_i & ~LOW_MASK;
                valid_r  <= 1'b1;
            end else begin
                target_r <= target_r;
                valid_r  <= valid_r;
            end
        end
    end

    assign target_o   = target_r;
    assign valid_o    = valid_r;
    assign misalign_o = misalign_r;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: run/idle/hold sequencer plus the PC register.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = PC_DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_DEF_RESET_VECTOR),
    parameter int              INSN_BYTES   = PC_DEF_INSN_BYTES
) (
    input  logic     clk_i,
    input  logic     rst_n_i,
    pc_gen_if.slave  bus
);

    localparam int              ALIGN_BITS = align_bits(INSN_BYTES);
    localparam logic [XLEN-1:0] LOW_MASK   = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    pc_state_e       state_r;
    pc_state_e       state_next_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_next_s;
    logic            pc_valid_r;
    logic            advance_s;
    logic            capture_s;
    logic            clear_s;
    logic [XLEN-1:0] redirect_aligned_s;
    logic [XLEN-1:0] pending_target_s;
    logic            pending_valid_s;
    logic            misalign_s;

    assign advance_s          = ~bus.stall_i & bus.pc_write_i;
    assign redirect_aligned_s = bus.redirect_pc_i & ~LOW_MASK;

    pc_redirect_buf #(
        .XLEN       (XLEN),
        .INSN_BYTES (INSN_BYTES)
    ) u_redirect_buf (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .capture    (capture_s),
        .clear      (clear_s),
        .target_i   (bus.redirect_pc_i),
        .target_o   (pending_target_s),
        .valid_o    (pending_valid_s),
        .misalign_o (misalign_s)
    );

    // Next state, next PC and redirect-buffer controls; start low overrides all
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        capture_s    = 1'b0;
        clear_s      = 1'b0;
        if (!bus.start_i) begin
            state_next_s = PC_IDLE;
            pc_next_s    = RESET_VECTOR;
            clear_s      = 1'b1;
        end else begin
            case (state_r)
                PC_IDLE: begin
                    state_next_s = PC_RUN;
                end
                PC_RUN: begin
                    if (advance_s) begin
                        if (bus.redirect_i) begin
                            pc_next_s = redirect_aligned_s;
                            capture_s = 1'b1;
                            clear_s   = 1'b1;
                        end else begin
                            pc_next_s = pc_r + XLEN'(INSN_BYTES);
                        end
                    end else if (bus.redirect_i) begin
                        capture_s    = 1'b1;
                        state_next_s = PC_HOLD;
                    end else begin
                        state_next_s = PC_RUN;
                    end
                end
                PC_HOLD: begin
                    if (advance_s) begin
                        pc_next_s    = bus.redirect_i ? redirect_aligned_s : pending_target_s;
                        capture_s    = bus.redirect_i;
                        clear_s      = 1'b1;
                        state_next_s = PC_RUN;
                    end else if (bus.redirect_i) begin
                        capture_s = 1'b1;
                    end else begin
                        state_next_s = PC_HOLD;
                    end
                end
                default: begin
                    state_next_s = PC_IDLE;
                    pc_next_s    = RESET_VECTOR;
                    clear_s      = 1'b1;
                end
            endcase
        end
    end

    // State, PC and fetch-valid registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r    <= PC_IDLE;
            pc_r       <= RESET_VECTOR;
            pc_valid_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            pc_r       <= pc_next_s;
            pc_valid_r <= (state_next_s != PC_IDLE);
        end
    end

    assign bus.pc_o               = pc_r;
    assign bus.pc_valid_o         = pc_valid_r;
    assign bus.misalign_o         = misalign_s;
    assign bus.redirect_pending_o = pending_valid_s;

endmodule
